// File: rtl/sync_up_counter.sv
// sync_up_counter
//   Synchronous binary up-counter, 0..MAX_COUNT, then wraps to 0.
//   Features: enable, parallel load with clamp to MAX_COUNT, and a
//   combinational terminal-count flag (tc) for cascading stages.
//   It also drives a registered one-cycle wrap pulse.
//   Next-state logic uses per-bit toggle conditions (ripple of lower ones).
//   Optional build macro: SYNC_UP_COUNTER_SATURATE_EN
//     defined   -> counter holds at MAX_COUNT, wrap tied low
//     undefined -> counter wraps MAX_COUNT -> 0 with a wrap pulse
module sync_up_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next;
  logic             w_next_wrap;
  logic             w_at_max;

  assign w_at_max       = (r_out == LP_MAX);
  assign w_load_clamped = (load_val > LP_MAX) ? LP_MAX : load_val;
  assign w_inc          = r_out ^ w_toggle;

  // Per-bit toggle: bit i flips when enabled and every lower bit is 1
  always_comb begin : toggle_gen
    logic v_lower_ones;
    v_lower_ones = 1'b1;
    w_toggle     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_toggle[i]  = en & v_lower_ones;
      v_lower_ones = v_lower_ones & r_out[i];
    end
  end

  // Next-state select: load beats enable; terminal compare caps the count
  always_comb begin
    w_next      = r_out;
    w_next_wrap = 1'b0;
    if (load) begin
      w_next = w_load_clamped;
    end else if (en) begin
      if (w_at_max) begin
`ifdef SYNC_UP_COUNTER_SATURATE_EN
        w_next = r_out;
`else
        w_next      = '0;
        w_next_wrap = 1'b1;
`endif
      end else begin
        w_next = w_inc;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next;
      r_wrap <= w_next_wrap;
    end
  end

  assign out  = r_out;
  assign wrap = r_wrap;
  assign tc   = en & w_at_max;

endmodule
